// File: rtl/task_import_accum.sv
// Multi-channel accumulator whose datapath add is a static task imported from
// interface I_acc through modport P; adds wrap/saturate, registered outputs and a dump engine.
`timescale 1ns/1ps

interface I_acc #(
    parameter int WIDTH = 8
);
    task static add_acc(
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        input  logic             sat,
        output logic [WIDTH-1:0] sum,
        output logic             carry
    );
        {carry, sum} = {1'b0, a} + {1'b0, b};
        if (sat && carry) begin
            sum = '1;
        end
    endtask

    modport P (import add_acc);
endinterface

module task_import_accum #(
    parameter int WIDTH       = 8,
    parameter int NCHAN       = 4,
    parameter int SATURATE    = 1,
    parameter int CLR_ON_DUMP = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    I_acc.P                          p,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [$clog2(NCHAN)-1:0] i_chan,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_clr,
    input  logic                     i_dump,
    output logic                     o_valid,
    output logic [$clog2(NCHAN)-1:0] o_chan,
    output logic [WIDTH-1:0]         o_sum,
    output logic                     o_ovf,
    output logic                     o_dump_busy
);
    localparam int CW = $clog2(NCHAN);
    localparam logic [CW:0]   NCHAN_L = (CW+1)'(NCHAN);
    localparam logic [CW-1:0] LAST    = CW'(NCHAN - 1);
    localparam logic          SAT_EN  = (SATURATE != 0);
    localparam logic          CLR_EN  = (CLR_ON_DUMP != 0);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   dump_idx;
    logic [WIDTH-1:0] acc [NCHAN];
    logic            ovf [NCHAN];

    logic            accept;
    logic            in_range;
    logic            upd_hit;
    logic [CW-1:0]   sel;
    logic [WIDTH-1:0] add_sum;
    logic            add_carry;
    logic [WIDTH-1:0] upd_val;
    logic            upd_ovf;

    assign o_ready     = (state == IDLE);
    assign o_dump_busy = (state == DUMP);

    always_comb begin
        accept    = i_valid && o_ready;
        in_range  = ({1'b0, i_chan} < NCHAN_L);
        upd_hit   = accept && in_range;
        // Out-of-range requests read channel 0 so the array is never indexed past its end.
        sel       = in_range ? i_chan : '0;
        add_sum   = '0;
        add_carry = 1'b0;
        p.add_acc(acc[sel], i_data, SAT_EN, add_sum, add_carry);
        upd_val   = i_clr ? i_data : add_sum;
        upd_ovf   = i_clr ? 1'b0 : (ovf[sel] | add_carry);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_dump) state_next = DUMP;
            DUMP: if (dump_idx == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            dump_idx <= '0;
            o_valid  <= 1'b0;
            o_chan   <= '0;
            o_sum    <= '0;
            o_ovf    <= 1'b0;
            for (int unsigned i = 0; i < NCHAN; i++) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end
        end else begin
            state   <= state_next;
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    dump_idx <= '0;
                    if (upd_hit) begin
                        acc[sel] <= upd_val;
                        ovf[sel] <= upd_ovf;
                        o_valid  <= 1'b1;
                        o_chan   <= sel;
                        o_sum    <= upd_val;
                        o_ovf    <= upd_ovf;
                    end
                end
                DUMP: begin
                    o_valid <= 1'b1;
                    o_chan  <= dump_idx;
                    o_sum   <= acc[dump_idx];
                    o_ovf   <= ovf[dump_idx];
                    if (CLR_EN) begin
                        acc[dump_idx] <= '0;
                        ovf[dump_idx] <= 1'b0;
                    end
                    dump_idx <= (dump_idx == LAST) ? '0 : dump_idx + CW'(1);
                end
                default: dump_idx <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_task_import_accum.sv
// Directed bench: three accumulator instances (saturating, wrap+clear-on-dump,
// three channels) driven one at a time with hand-computed expectations.
`timescale 1ns/1ps

module tb_task_import_accum;
    logic       clk = 1'b0;
    logic       rst   [3];
    logic       valid [3];
    logic [1:0] chan  [3];
    logic [7:0] data  [3];
    logic       clr   [3];
    logic       dump  [3];
    logic       ready [3];
    logic       ovalid[3];
    logic [1:0] ochan [3];
    logic [7:0] osum  [3];
    logic       oovf  [3];
    logic       busy  [3];

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_s [4];
    logic       exp_o [4];

    always #5 clk = ~clk;

    I_acc #(.WIDTH(8)) acc_if0 ();
    I_acc #(.WIDTH(8)) acc_if1 ();
    I_acc #(.WIDTH(8)) acc_if2 ();

    task_import_accum #(.WIDTH(8), .NCHAN(4), .SATURATE(1), .CLR_ON_DUMP(0)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .p(acc_if0), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_chan(chan[0]), .i_data(data[0]), .i_clr(clr[0]), .i_dump(dump[0]),
        .o_valid(ovalid[0]), .o_chan(ochan[0]), .o_sum(osum[0]), .o_ovf(oovf[0]),
        .o_dump_busy(busy[0]));

    task_import_accum #(.WIDTH(8), .NCHAN(4), .SATURATE(0), .CLR_ON_DUMP(1)) dut1 (
        .i_clk(clk), .i_rst(rst[1]), .p(acc_if1), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_chan(chan[1]), .i_data(data[1]), .i_clr(clr[1]), .i_dump(dump[1]),
        .o_valid(ovalid[1]), .o_chan(ochan[1]), .o_sum(osum[1]), .o_ovf(oovf[1]),
        .o_dump_busy(busy[1]));

    task_import_accum #(.WIDTH(8), .NCHAN(3), .SATURATE(1), .CLR_ON_DUMP(0)) dut2 (
        .i_clk(clk), .i_rst(rst[2]), .p(acc_if2), .i_valid(valid[2]), .o_ready(ready[2]),
        .i_chan(chan[2]), .i_data(data[2]), .i_clr(clr[2]), .i_dump(dump[2]),
        .o_valid(ovalid[2]), .o_chan(ochan[2]), .o_sum(osum[2]), .o_ovf(oovf[2]),
        .o_dump_busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [1:0] c,
                         input logic [7:0] x, input logic cl, input logic dm);
        valid[d] = v;
        chan[d]  = c;
        data[d]  = x;
        clr[d]   = cl;
        dump[d]  = dm;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    endtask

    // Apply one update on the given cycle and check its beat on the next.
    task automatic upd(input int d, input logic [1:0] c, input logic [7:0] x,
                       input logic cl, input logic [7:0] want_s, input logic want_o);
        drive(d, 1'b1, c, x, cl, 1'b0);
        tick();
        check($sformatf("d%0d upd valid", d), ovalid[d], 1);
        check($sformatf("d%0d upd chan", d), ochan[d], c);
        check($sformatf("d%0d upd sum", d), osum[d], want_s);
        check($sformatf("d%0d upd ovf", d), oovf[d], want_o);
        idle(d);
    endtask

    // Called in the first cycle after dump acceptance; checks the n dump beats.
    task automatic dump_seq(input int d, input int n, input int blk);
        for (int k = 0; k < n; k++) begin
            if (k == blk) drive(d, 1'b1, 2'd0, 8'd9, 1'b0, 1'b0);
            else idle(d);
            tick();
            check($sformatf("d%0d dump%0d valid", d, k), ovalid[d], 1);
            check($sformatf("d%0d dump%0d chan", d, k), ochan[d], k);
            check($sformatf("d%0d dump%0d sum", d, k), osum[d], exp_s[k]);
            check($sformatf("d%0d dump%0d ovf", d, k), oovf[d], exp_o[k]);
            check($sformatf("d%0d dump%0d ready", d, k), ready[d], (k == n - 1) ? 1 : 0);
        end
        idle(d);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            idle(d);
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d rst valid", d), ovalid[d], 0);
            check($sformatf("d%0d rst sum", d), osum[d], 0);
            check($sformatf("d%0d rst ready", d), ready[d], 1);
            check($sformatf("d%0d rst busy", d), busy[d], 0);
        end

        // Saturating channel 1, back to back.
        upd(0, 2'd1, 8'd100, 1'b0, 8'd100, 1'b0);
        upd(0, 2'd1, 8'd100, 1'b0, 8'd200, 1'b0);
        upd(0, 2'd1, 8'd100, 1'b0, 8'd255, 1'b1);
        tick();
        check("d0 pulse end", ovalid[0], 0);
        upd(0, 2'd0, 8'd3, 1'b0, 8'd3, 1'b0);
        upd(0, 2'd2, 8'd44, 1'b1, 8'd44, 1'b0);

        // Dump together with an update of channel 3; blocked update mid-dump.
        drive(0, 1'b1, 2'd3, 8'd7, 1'b0, 1'b1);
        tick();
        check("d0 dump upd valid", ovalid[0], 1);
        check("d0 dump upd chan", ochan[0], 3);
        check("d0 dump upd sum", osum[0], 7);
        check("d0 dump ready low", ready[0], 0);
        check("d0 dump busy", busy[0], 1);
        exp_s = '{8'd3, 8'd255, 8'd44, 8'd7};
        exp_o = '{1'b0, 1'b1, 1'b0, 1'b0};
        dump_seq(0, 4, 1);
        tick();
        check("d0 after dump valid", ovalid[0], 0);

        // Second dump, reset on its second beat.
        drive(0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        tick();
        idle(0);
        check("d0 dump2 no upd beat", ovalid[0], 0);
        check("d0 dump2 busy", busy[0], 1);
        tick();
        check("d0 dump2 ch0 unchanged", osum[0], 3);
        tick();
        check("d0 dump2 ch1 sum", osum[0], 255);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("d0 midrst valid", ovalid[0], 0);
        check("d0 midrst ready", ready[0], 1);
        check("d0 midrst busy", busy[0], 0);
        drive(0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        tick();
        check("d0 dump3 no upd beat", ovalid[0], 0);
        exp_s = '{8'd0, 8'd0, 8'd0, 8'd0};
        exp_o = '{1'b0, 1'b0, 1'b0, 1'b0};
        dump_seq(0, 4, -1);

        // Wrap mode with clear-on-dump.
        upd(1, 2'd2, 8'd200, 1'b0, 8'd200, 1'b0);
        upd(1, 2'd2, 8'd100, 1'b0, 8'd44, 1'b1);
        upd(1, 2'd2, 8'd5, 1'b1, 8'd5, 1'b0);
        upd(1, 2'd1, 8'd255, 1'b0, 8'd255, 1'b0);
        upd(1, 2'd1, 8'd1, 1'b0, 8'd0, 1'b1);
        drive(1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        tick();
        check("d1 dump no upd beat", ovalid[1], 0);
        check("d1 dump busy", busy[1], 1);
        exp_s = '{8'd0, 8'd0, 8'd5, 8'd0};
        exp_o = '{1'b0, 1'b1, 1'b0, 1'b0};
        dump_seq(1, 4, -1);
        drive(1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        tick();
        check("d1 dump2 busy", busy[1], 1);
        exp_s = '{8'd0, 8'd0, 8'd0, 8'd0};
        exp_o = '{1'b0, 1'b0, 1'b0, 1'b0};
        dump_seq(1, 4, -1);

        // Three channels, out-of-range request.
        upd(2, 2'd2, 8'd10, 1'b0, 8'd10, 1'b0);
        drive(2, 1'b1, 2'd3, 8'd50, 1'b0, 1'b0);
        tick();
        idle(2);
        check("d2 oor no beat", ovalid[2], 0);
        check("d2 oor ready", ready[2], 1);
        upd(2, 2'd0, 8'd1, 1'b0, 8'd1, 1'b0);
        drive(2, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        tick();
        check("d2 dump busy", busy[2], 1);
        exp_s = '{8'd1, 8'd0, 8'd10, 8'd0};
        exp_o = '{1'b0, 1'b0, 1'b0, 1'b0};
        dump_seq(2, 3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
